// File: rtl/uart_rx_byte_pkg.sv
// Shared types and constants for the byte-wide UART receiver.
// Holds the FSM state encoding, data width and the bit-period helper.
package uart_rx_byte_pkg;

    localparam int DATA_BITS  = 8;
    localparam int BAUD_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer for the UART receiver: free-running 16-bit counter
// with half-bit and full-bit ticks, restarted from zero by clear.
module uart_baud_cnt
    import uart_rx_byte_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam logic [BAUD_CNT_W-1:0] HALF_TC = BAUD_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_CNT_W-1:0] FULL_TC = BAUD_CNT_W'(CLKS_PER_BIT - 1);

    logic [BAUD_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (cnt == FULL_TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign half_tick = (cnt == HALF_TC);
    assign full_tick = (cnt == FULL_TC);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with mid-bit sampling, framing check and bad-byte suppression.
// Optional parity (8E1/8O1) is built in when UART_RX_PARITY_EN is defined.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  WAIT_IDLE | line must read high for one full bit period before arming
//  IDLE      | armed, waiting for a falling edge on the synchronized line
//  START     | confirm start bit at its midpoint, reject short glitches
//  DATA      | sample 8 data bits, LSB first, one bit period apart
//  PARITY    | sample and check the parity bit (parity build only)
//  STOP      | sample stop bit, publish byte or flag the error
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t            state;
    logic                 rxd_meta;
    logic                 rxd_s;
    logic                 rxd_s_d;
    logic                 rxd_fall;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 baud_clear;
    logic                 half_tick;
    logic                 full_tick;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_s_d  <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_s_d  <= rxd_s;
        end
    end

    assign rxd_fall = rxd_s_d & ~rxd_s;

    // The timer is re-zeroed at the start edge and again at the start midpoint,
    // so every later full tick lands in the middle of a bit.
    always_comb begin
        baud_clear = 1'b0;
        case (state)
            ST_WAIT_IDLE: baud_clear = ~rxd_s;
            ST_IDLE:      baud_clear = 1'b1;
            ST_START:     baud_clear = half_tick;
            default:      baud_clear = 1'b0;
        endcase
    end

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (baud_clear),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_WAIT_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            parity_bad <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                ST_WAIT_IDLE: begin
                    if (rxd_s && full_tick) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (rxd_fall) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (half_tick) begin
                        if (!rxd_s) begin
                            state   <= ST_DATA;
                            rx_busy <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (full_tick) begin
                        shift <= {rxd_s, shift[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (full_tick) begin
                        parity_bad <= rxd_s ^ (^shift) ^ PARITY_ODD;
                        state      <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (full_tick) begin
                        rx_busy <= 1'b0;
                        // A low stop bit may be a break; re-qualify the idle line first.
                        if (!rxd_s) begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bad) begin
                            parity_err <= 1'b1;
                            state      <= ST_IDLE;
`endif
                        end else begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_WAIT_IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule
